// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: PC enable and per-bar enable/flush sequencing for the 5-stage core.
// Define PIPE_PERF_CNT_EN to add the stall_cycles/flush_cycles performance counters.
module pipeline_hazard_ctrl #(
    parameter int REG_W = 5
`ifdef PIPE_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req_3,
    input  logic             ld_2,
    input  logic [REG_W-1:0] ld_rt_2,
    input  logic [REG_W-1:0] rs_1,
    input  logic [REG_W-1:0] rt_1,
    input  logic             uses_rt_1,
    input  logic             redirect_3,
    input  logic             halt_4,
    output logic             pc_en,
    output logic             en_1,
    output logic             en_2,
    output logic             en_3,
    output logic             en_4,
    output logic             flush_1,
    output logic             flush_2,
    output logic             flush_3,
    output logic             flush_4,
    output logic             halt
`ifdef PIPE_PERF_CNT_EN
    , output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
`endif
);
    typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;
    state_t state, next_state;
    logic lu, dmiss, redir_rule;
    logic [3:0] en, fl;
    assign lu = ld_2 && ld_rt_2 != '0 && (ld_rt_2 == rs_1 || (uses_rt_1 && ld_rt_2 == rt_1));
    assign dmiss = dmem_req_3 & ~dhit;
    assign {en_1, en_2, en_3, en_4} = en;
    assign {flush_1, flush_2, flush_3, flush_4} = fl;
    // Priority decode: a pending data miss freezes the pipe, otherwise halt > miss > redirect > load-use > ifetch miss.
    always_comb begin
        pc_en = 1'b0;
        en = 4'b0000;
        fl = 4'b0000;
        redir_rule = 1'b0;
        next_state = state;
        if (!nRST) begin
            en = 4'b1111;
            fl = 4'b1111;
            next_state = RUN;
        end else if (state == HALTED) begin
            next_state = HALTED;
        end else if (state == DWAIT && !dhit) begin
            next_state = DWAIT;
        end else if (halt_4) begin
            en = 4'b0001;
            next_state = HALTED;
        end else if (state == RUN && dmiss) begin
            next_state = DWAIT;
        end else begin
            next_state = RUN;
            if (redirect_3) begin
                pc_en = 1'b1;
                en = 4'b1111;
                fl = 4'b1110;
                redir_rule = 1'b1;
            end else if (lu) begin
                en = 4'b0111;
                fl = 4'b0100;
            end else if (!ihit) begin
                en = 4'b1111;
                fl = 4'b1000;
            end else begin
                pc_en = 1'b1;
                en = 4'b1111;
            end
        end
    end
    // State register with sticky halt, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= RUN;
            halt <= 1'b0;
        end else begin
            state <= next_state;
            halt <= next_state == HALTED;
        end
    end
`ifdef PIPE_PERF_CNT_EN
    // Stall and redirect-flush cycle counters; frozen once halted.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else if (state != HALTED) begin
            stall_cycles <= stall_cycles + CNT_W'(!pc_en);
            flush_cycles <= flush_cycles + CNT_W'(redir_rule);
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;
    logic CLK = 1'b0;
    logic nRST, ihit, dhit, dmem_req_3, ld_2, uses_rt_1, redirect_3, halt_4;
    logic [4:0] ld_rt_2, rs_1, rt_1;
    logic pc_en, en_1, en_2, en_3, en_4, flush_1, flush_2, flush_3, flush_4, halt;
    logic [9:0] outs, exp_o;
    int checks = 0;
    int errors = 0;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    pipeline_hazard_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req_3(dmem_req_3),
        .ld_2(ld_2), .ld_rt_2(ld_rt_2), .rs_1(rs_1), .rt_1(rt_1), .uses_rt_1(uses_rt_1),
        .redirect_3(redirect_3), .halt_4(halt_4), .pc_en(pc_en),
        .en_1(en_1), .en_2(en_2), .en_3(en_3), .en_4(en_4),
        .flush_1(flush_1), .flush_2(flush_2), .flush_3(flush_3), .flush_4(flush_4),
        .halt(halt)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    // {pc_en, en_1..en_4, flush_1..flush_4, halt}
    assign outs = {pc_en, en_1, en_2, en_3, en_4, flush_1, flush_2, flush_3, flush_4, halt};

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle;
        ihit = 1'b1; dhit = 1'b0; dmem_req_3 = 1'b0; ld_2 = 1'b0; uses_rt_1 = 1'b0;
        redirect_3 = 1'b0; halt_4 = 1'b0; ld_rt_2 = '0; rs_1 = '0; rt_1 = '0;
    endtask

    task automatic test_reset;
        idle();
        nRST = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            exp_o = 10'b0_1111_1111_0;
            checks++; if (outs !== exp_o) begin errors++; $display("FAIL reset_%0d: got %b expected %b", i, outs, exp_o); end
            tick();
        end
        nRST = 1'b1;
        #2;
        exp_o = 10'b1_1111_0000_0;
        checks++; if (outs !== exp_o) begin errors++; $display("FAIL first_run: got %b expected %b", outs, exp_o); end
        tick();
    endtask

    task automatic test_load_use;
        ld_2 = 1'b1; ld_rt_2 = 5'd5; rs_1 = 5'd5;
        #2;
        exp_o = 10'b0_0111_0100_0;
        checks++; if (outs !== exp_o) begin errors++; $display("FAIL lu_rs: got %b expected %b", outs, exp_o); end
        tick();
        ld_2 = 1'b0;
        #2;
        exp_o = 10'b1_1111_0000_0;
        checks++; if (outs !== exp_o) begin errors++; $display("FAIL lu_release: got %b expected %b", outs, exp_o); end
        tick();
        ld_2 = 1'b1; ld_rt_2 = 5'd0; rs_1 = 5'd0; rt_1 = 5'd0; uses_rt_1 = 1'b1;
        #2;
        checks++; if (outs !== exp_o) begin errors++; $display("FAIL lu_zero: got %b expected %b", outs, exp_o); end
        tick();
        idle();
    endtask

    task automatic test_dmiss_redirect;
        dmem_req_3 = 1'b1; dhit = 1'b0; redirect_3 = 1'b1;
        exp_o = 10'b0_0000_0000_0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++; if (outs !== exp_o) begin errors++; $display("FAIL dmiss_freeze_%0d: got %b expected %b", i, outs, exp_o); end
            tick();
        end
        dhit = 1'b1;
        #2;
        exp_o = 10'b1_1111_1110_0;
        checks++; if (outs !== exp_o) begin errors++; $display("FAIL dhit_redirect: got %b expected %b", outs, exp_o); end
        tick();
        idle();
        #2;
        exp_o = 10'b1_1111_0000_0;
        checks++; if (outs !== exp_o) begin errors++; $display("FAIL back_in_run: got %b expected %b", outs, exp_o); end
`ifdef PIPE_PERF_CNT_EN
        checks++; if (stall_cycles !== 32'd4) begin errors++; $display("FAIL stall_cnt_a: got %0d expected 4", stall_cycles); end
        checks++; if (flush_cycles !== 32'd1) begin errors++; $display("FAIL flush_cnt_a: got %0d expected 1", flush_cycles); end
`endif
        tick();
    endtask

    task automatic test_back_to_back;
        dmem_req_3 = 1'b1; dhit = 1'b0;
        #2;
        exp_o = 10'b0_0000_0000_0;
        checks++; if (outs !== exp_o) begin errors++; $display("FAIL b2b_miss: got %b expected %b", outs, exp_o); end
        tick();
        dhit = 1'b1; ihit = 1'b0;
        #2;
        exp_o = 10'b0_1111_1000_0;
        checks++; if (outs !== exp_o) begin errors++; $display("FAIL b2b_dhit_imiss: got %b expected %b", outs, exp_o); end
        tick();
        idle();
        #2;
        exp_o = 10'b1_1111_0000_0;
        checks++; if (outs !== exp_o) begin errors++; $display("FAIL b2b_run: got %b expected %b", outs, exp_o); end
        tick();
    endtask

    task automatic test_ihit;
        ihit = 1'b0;
        exp_o = 10'b0_1111_1000_0;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++; if (outs !== exp_o) begin errors++; $display("FAIL imiss_%0d: got %b expected %b", i, outs, exp_o); end
            tick();
        end
        idle();
    endtask

    task automatic test_lu_rt;
        ld_2 = 1'b1; ld_rt_2 = 5'd7; rs_1 = 5'd3; rt_1 = 5'd7; uses_rt_1 = 1'b1;
        #2;
        exp_o = 10'b0_0111_0100_0;
        checks++; if (outs !== exp_o) begin errors++; $display("FAIL lu_rt: got %b expected %b", outs, exp_o); end
        tick();
        uses_rt_1 = 1'b0;
        #2;
        exp_o = 10'b1_1111_0000_0;
        checks++; if (outs !== exp_o) begin errors++; $display("FAIL lu_rt_unused: got %b expected %b", outs, exp_o); end
        tick();
        uses_rt_1 = 1'b1; ihit = 1'b0;
        #2;
        exp_o = 10'b0_0111_0100_0;
        checks++; if (outs !== exp_o) begin errors++; $display("FAIL lu_over_imiss: got %b expected %b", outs, exp_o); end
        tick();
        redirect_3 = 1'b1;
        #2;
        exp_o = 10'b1_1111_1110_0;
        checks++; if (outs !== exp_o) begin errors++; $display("FAIL redirect_over_lu: got %b expected %b", outs, exp_o); end
        tick();
        idle();
    endtask

    task automatic test_halt;
        dmem_req_3 = 1'b1; dhit = 1'b0; halt_4 = 1'b1;
        #2;
        exp_o = 10'b0_0001_0000_0;
        checks++; if (outs !== exp_o) begin errors++; $display("FAIL halt_retire: got %b expected %b", outs, exp_o); end
        tick();
        idle();
        redirect_3 = 1'b1;
        exp_o = 10'b0_0000_0000_1;
        for (int i = 0; i < 10; i++) begin
            #2;
            checks++; if (outs !== exp_o) begin errors++; $display("FAIL halted_%0d: got %b expected %b", i, outs, exp_o); end
            tick();
        end
`ifdef PIPE_PERF_CNT_EN
        checks++; if (stall_cycles !== 32'd11) begin errors++; $display("FAIL stall_cnt_halt: got %0d expected 11", stall_cycles); end
        checks++; if (flush_cycles !== 32'd2) begin errors++; $display("FAIL flush_cnt_halt: got %0d expected 2", flush_cycles); end
`endif
        idle();
        nRST = 1'b0;
        #2;
        exp_o = 10'b0_1111_1111_1;
        checks++; if (outs !== exp_o) begin errors++; $display("FAIL halt_reset: got %b expected %b", outs, exp_o); end
        tick();
        nRST = 1'b1;
        #2;
        exp_o = 10'b1_1111_0000_0;
        checks++; if (outs !== exp_o) begin errors++; $display("FAIL after_reset: got %b expected %b", outs, exp_o); end
`ifdef PIPE_PERF_CNT_EN
        checks++; if (stall_cycles !== 32'd0 || flush_cycles !== 32'd0) begin errors++; $display("FAIL cnt_clear: got %0d/%0d expected 0/0", stall_cycles, flush_cycles); end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_dmiss_redirect();
        test_back_to_back();
        test_ihit();
        test_lu_rt();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
